// File: rtl/pcs_10g_pkg.sv
// Shared PCS 10G definitions.
//   BLOCK_W       : 64b/66b payload width
//   HEAD_W        : sync header width
//   sync_hdr_t    : legal sync header values (data / control)
//   GEARBOX_BUF_W : transmit gearbox staging buffer width
package pcs_10g_pkg;

  localparam int unsigned BLOCK_W       = 64;
  localparam int unsigned HEAD_W        = 2;
  localparam int unsigned GEARBOX_BUF_W = 128;

  typedef enum logic [1:0] {
    SYNC_DATA = 2'b01,
    SYNC_CTRL = 2'b10
  } sync_hdr_t;

endpackage

// File: rtl/pcs_10g_gearbox.sv
// 10G PCS transmit gearbox: 66-bit blocks in, continuous 64-bit words out.
// 32 blocks fill exactly 33 words, so upstream is stalled one cycle in 33.
//   clk      : PCS transmit clock
//   nreset   : asynchronous active-low reset
//   in_v_i   : block valid from the encoder
//   head_i   : sync header, bit 0 first on the line
//   data_i   : scrambled payload, bit 0 first after the header
//   ready_o  : block accepted this cycle when in_v_i is also high
//   data_v_o : data_o holds a freshly emitted word
//   data_o   : output word, bit 0 first on the line
module pcs_10g_gearbox #(
  parameter int unsigned BLOCK_W = pcs_10g_pkg::BLOCK_W,
  parameter int unsigned HEAD_W  = pcs_10g_pkg::HEAD_W,
  parameter int unsigned DATA_W  = 64
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               in_v_i,
  input  logic [HEAD_W-1:0]  head_i,
  input  logic [BLOCK_W-1:0] data_i,
  output logic               ready_o,
  output logic               data_v_o,
  output logic [DATA_W-1:0]  data_o
);

  import pcs_10g_pkg::*;

  localparam int unsigned BLK_W = BLOCK_W + HEAD_W;
  localparam int unsigned BUF_W = GEARBOX_BUF_W;

  // Valid bits always sit in buf_q[fill_q-1:0]; oldest bit at index 0.
  logic [BUF_W-1:0] buf_q;
  logic [7:0]       fill_q;

  logic             out_en;
  logic [7:0]       rem;
  logic             accept;
  logic [BUF_W-1:0] blk_ext;

  always_comb begin
    out_en  = (fill_q >= 8'(DATA_W));
    rem     = out_en ? (fill_q - 8'(DATA_W)) : fill_q;
    // Space for a whole block exists only while rem <= BUF_W - BLK_W.
    ready_o = (rem <= 8'(BUF_W - BLK_W));
    accept  = in_v_i & ready_o;
    blk_ext = BUF_W'({data_i, head_i});
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      buf_q    <= '0;
      fill_q   <= '0;
      data_o   <= '0;
      data_v_o <= 1'b0;
    end else begin
      // Drain the oldest word and append the new block behind the residue
      // in the same edge; the shifted-out word never overlaps the insert.
      buf_q    <= (out_en ? (buf_q >> DATA_W) : buf_q)
                | (accept ? (blk_ext << rem) : '0);
      fill_q   <= accept ? (rem + 8'(BLK_W)) : rem;
      data_v_o <= out_en;
      if (out_en) begin
        data_o <= buf_q[DATA_W-1:0];
      end
    end
  end

  a_fill_bound : assert property (@(posedge clk) disable iff (!nreset)
    fill_q <= 8'(BUF_W));

  a_no_x_out : assert property (@(posedge clk) disable iff (!nreset)
    data_v_o |-> !$isunknown(data_o));

  // Stall is always a single cycle: a full buffer drains one word and frees space.
  a_stall_single : assert property (@(posedge clk) disable iff (!nreset)
    !ready_o |=> ready_o);

endmodule

// File: doc/pcs_10g_gearbox.md
# pcs_10g_gearbox

The 10G PCS transmit gearbox sits directly downstream of the 64b/66b encoder (and its scrambler). It accepts one 66-bit block per cycle, made of a 2-bit sync header and a 64-bit payload, and emits a continuous stream of 64-bit words toward the SERDES. Because 32 blocks (2112 bits) fill exactly 33 words, it backpressures upstream one cycle in every 33 using a valid/ready handshake.

## Interface
- `BLOCK_W`, default 64: payload width per block.
- `HEAD_W`, default 2: sync header width.
- `DATA_W`, default 64: output word width. Only 64 is supported.
- `clk`  in  1: PCS transmit clock.
- `nreset`  in  1: reset. One clock; reset is asynchronous and active-low.
- `in_v_i`  in  1: block valid from the encoder.
- `head_i`  in  HEAD_W: sync header. `head_i[0]` is transmitted first.
- `data_i`  in  BLOCK_W: scrambled payload. `data_i[0]` is transmitted first, after the header.
- `ready_o`  out  1: the gearbox accepts a block this cycle.
- `data_v_o`  out  1: `data_o` holds a valid word.
- `data_o`  out  DATA_W: output word. Bit 0 is transmitted first.

## Operation
- **Block vector:** `blk = {data_i, head_i}`, 66 bits, LSB first on the line.
- **State:** 128-bit buffer `buf` and fill counter `fill` (8 bits, range 0..128). Valid bits always occupy `buf[fill-1:0]`. Both are held in flops.
- **Accept:** a block is accepted when `in_v_i & ready_o`.
- **Per rising edge:**
  - `out = (fill >= 64)`.
  - `rem = out ? fill-64 : fill`; the buffer shifts right by 64 when `out` is set.
  - On accept, `blk` is OR-ed in at bit position `rem` and `fill <= rem+66`; otherwise `fill <= rem`.
- **Output:** when `out` is set, `data_o <= buf[63:0]` and `data_v_o <= 1`. Otherwise `data_v_o <= 0` and `data_o` holds its last value.
- **Ready:** `ready_o = (rem <= 62)`, combinational from the registered `fill` only. It never depends on `in_v_i`.
- **Steady state:** with `in_v_i` held high, `rem` after output cycles through 0,2,4,…,62,64.
  - At `rem == 64`, `ready_o` is low for one cycle. Period: 33 cycles, 32 accepts, 33 words.
- **Upstream bubbles:** if `in_v_i` is low while `ready_o` is high, nothing is accepted. `data_v_o` drops once `fill < 64`, and the stream resumes seamlessly on the next accept. No bits are lost or duplicated.
- **Blocked input:** `in_v_i` asserted while `ready_o` is low is ignored; upstream must hold the block.
- **Overflow:** none possible; `fill` never exceeds 128 (62+66).
- **Reset (async, including mid-stream):**
  - `buf`, `fill`, `data_o` = 0; `data_v_o` = 0.
  - `ready_o` = 1 while in reset, since `fill == 0`.
  - Partial blocks are discarded; after release, alignment restarts from the first accepted block.

## Timing
- `ready_o` is combinational from flops, valid early in the cycle. The upstream encoder must gate its own state advance on it.
- **Latency:** the first block accepted at edge E0 after reset appears on `data_o` (`data_v_o` = 1) after edge E1, with `data_o = blk[63:0]`.
- In steady state `data_v_o` is high every cycle from E1 onward.
- Each input bit reaches `data_o` 1 or 2 cycles after acceptance.

## Structure
- Shared package `pcs_10g_pkg`: `BLOCK_W`, `HEAD_W`, the `SYNC_DATA` = 2'b01 and `SYNC_CTRL` = 2'b10 constants, and `GEARBOX_BUF_W` = 128.
- **Sub-modules:** none required. The shift/insert datapath stays inline in a single always block, with the fill counter logic alongside.
- **Formal:**
  - Assert `fill <= 128`.
  - Assert `ready_o` is low exactly once per 33 cycles under continuous `in_v_i`.
  - Assert no X on `data_o` when `data_v_o` is high.

## Test plan
- **Reset values:** hold `nreset` low → `data_v_o` = 0, `data_o` = 0, `ready_o` = 1.
- **First two words:**
  - blk0: `head_i` = 2'b01, `data_i` = 0; blk1: `head_i` = 2'b10, `data_i` = all ones.
  - Required: word0 = 64'h0000_0000_0000_0001; word1 = 64'hFFFF_FFFF_FFFF_FFF8.
- **Cadence:** continuous `in_v_i` for 330 cycles → `ready_o` low exactly 10 times, 33 cycles apart; 320 blocks accepted; `data_v_o` never drops after the first word.
- **Bit-exact stream:** random headers/payloads → concatenated output bitstream equals concatenated `{data_i, head_i}` bitstream, with no gaps and no duplicates.
- **Bubble:** drop `in_v_i` for 3 cycles mid-stream → `data_v_o` drops only when `fill < 64`; the stream resumes bit-exact.
- **Mid-stream reset:** assert `nreset` mid-stream at `fill` = 40 → outputs clear immediately (asynchronously). After release, the first word is the low 64 bits of the next accepted block.
